adc5g_gc_cal_ctrl: RTL and testbench
====================================

# adc5g_gc_cal_ctrl

Calibration sequencer for one ADC5G demux lane. It sits between the lane's capture registers and the gray-to-binary decode stage. On request it forces the decode into raw (binary) mode and checks the ADC ramp test pattern. It pulses bitslip until the ramp is seen cleanly, then hands the lane back with the configured gray-decode setting.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width in bits.
- SETTLE_CYC, 4, idle cycles after each bitslip before checking resumes (at least 1).
- CHECK_LEN, 16, consecutive correct ramp steps required for lock (at least 2).
- MAX_SLIP, 7, bitslips allowed before declaring failure.

Ports:
- clk, input, 1, lane sample clock. All logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin calibration.
- cfg_gray_en, input, 1, gray decode setting applied once calibration is not running.
- din, input, DATA_WIDTH, raw lane sample, valid every cycle.
- gray_en, output, 1, drives the decode stage's gray/bypass select.
- bitslip, output, 1, one-cycle pulse to the deserializer.
- busy, output, 1, high while calibration is running.
- locked, output, 1, high after a successful calibration.
- fail, output, 1, high after slip exhaustion.
- slip_cnt, output, $clog2(MAX_SLIP+1), number of bitslips issued in the current or last run.

## Operation
- State machine states: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE:
  - On start, clear slip_cnt, clear locked and fail, and go to SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles, then go to CHECK.
  - din is ignored here.
- CHECK:
  - First cycle: capture din as the reference. Step count = 0.
  - Each following cycle: if din equals previous sample + 1 (mod 2^DATA_WIDTH), increment the step count.
  - On the first mismatch, leave CHECK immediately.
  - Step count reaching CHECK_LEN-1 → LOCKED.
- Mismatch in CHECK:
  - If slip_cnt < MAX_SLIP → SLIP.
  - Otherwise → FAIL.
- SLIP:
  - One cycle: bitslip=1, slip_cnt increments.
  - Next state SETTLE.
- LOCKED and FAIL are terminal. start from either state restarts exactly as from IDLE.
- start while busy is ignored.
- gray_en = 0 whenever busy; otherwise gray_en = cfg_gray_en.
- busy = 1 in SETTLE, CHECK and SLIP.
- Wrap-around: 0xFF followed by 0x00 is a correct step at DATA_WIDTH=8.
- Reset mid-run aborts immediately. No pending bitslip survives reset.
- Reset values:
  - State IDLE.
  - bitslip, busy, locked, fail = 0.
  - slip_cnt = 0.
  - gray_en follows cfg_gray_en.

## Timing
- All outputs are registered except gray_en. gray_en is the combinational mux of busy and cfg_gray_en.
- start in cycle N → busy=1 in cycle N+1.
- Each bitslip pulse is exactly one cycle wide.
- Pulses are separated by at least SETTLE_CYC + 2 cycles.
- Best-case lock: locked=1 at N+1+SETTLE_CYC+CHECK_LEN. busy falls in the same cycle.
- A mismatch detected in cycle M → bitslip=1 in M+1.
- locked and fail are never high together.
- locked and fail each hold until the next accepted start or reset.

## Configuration
- GC_CAL_TIMEOUT_EN:
  - Defined: adds parameter TIMEOUT_CYC (default 4096) and a run-cycle counter.
    - The counter runs while busy.
    - Reaching TIMEOUT_CYC forces FAIL from any busy state. No bitslip is issued on that cycle.
  - Undefined: no counter. Termination is only by lock or slip exhaustion.
- All other behaviour is identical with or without the macro.

## Structure
- Package adc5g_cal_pkg holds:
  - The state enum type.
  - A localparam function for the slip_cnt width.
  - The default values of SETTLE_CYC, CHECK_LEN and MAX_SLIP.
- Sub-module adc5g_ramp_chk:
  - Registers the previous sample.
  - Outputs step_ok = (din == prev+1).
  - Keeps the step counter, cleared by the FSM.
- The top level holds the FSM, the settle counter, slip_cnt and the optional timeout.

## Test plan
All scenarios use DATA_WIDTH=8, SETTLE_CYC=4, CHECK_LEN=16, MAX_SLIP=7.
- Clean ramp: din increments every cycle, start pulsed → locked=1 exactly 21 cycles after start, slip_cnt=0, gray_en returns to cfg_gray_en=1.
- Misaligned ramp: din is correct only after 3 slips → exactly 3 single-cycle bitslip pulses, then locked=1 with slip_cnt=3.
- Constant din=0x5A → 7 bitslip pulses, then fail=1 with slip_cnt=7. No 8th pulse.
- Wrap-around: ramp starting at 0xF8 crosses 0xFF→0x00 inside the window → locked=1 with no slip.
- rst_n asserted during SLIP/SETTLE after 2 slips → on release all outputs are 0, state IDLE. A start while busy is shown to have no effect.
- With GC_CAL_TIMEOUT_EN and TIMEOUT_CYC=30 on constant din → fail=1 at cycle 30 of busy, slip_cnt < 7.

Source files
------------

// File: rtl/adc5g_cal_pkg.sv
// Shared types, defaults and width helpers for the ADC5G lane calibration sequencer.
package adc5g_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } cal_state_e;

  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_CHECK_LEN  = 16;
  localparam int DEF_MAX_SLIP   = 7;

  // Width of a counter holding 0 .. n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int slip_cnt_w(input int max_slip);
    return cnt_w(max_slip + 1);
  endfunction

endpackage

// File: rtl/adc5g_ramp_chk.sv
// Ramp-step detector: compares each lane sample against the previous one plus one
// and counts consecutive good steps until cleared by the sequencer.
module adc5g_ramp_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  input  logic                  inc_en,
  output logic                  step_ok,
  output logic [CNT_W-1:0]      step_cnt
);

  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] w_prev_inc;
  logic [CNT_W-1:0]      r_step_cnt;

  // Natural wrap of the add makes 0xFF -> 0x00 a valid step.
  assign w_prev_inc = r_prev + DATA_WIDTH'(1);
  assign step_ok    = (din == w_prev_inc);
  assign step_cnt   = r_step_cnt;

  // NOTE: r_prev is pure datapath but is reset anyway so step_ok is never X out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_step_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      r_prev <= din;
      if (clr) begin
        r_step_cnt <= '0;
      end else if (inc_en && step_ok) begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc5g_gc_cal_ctrl.sv
// ADC5G lane calibration sequencer: forces raw decode, bitslips until the ramp test
// pattern is seen cleanly, then restores gray decode. Optional GC_CAL_TIMEOUT_EN adds a run timeout.
module adc5g_gc_cal_ctrl
  import adc5g_cal_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CHECK_LEN  = DEF_CHECK_LEN,
  parameter int MAX_SLIP   = DEF_MAX_SLIP
`ifdef GC_CAL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              cfg_gray_en,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic                              gray_en,
  output logic                              bitslip,
  output logic                              busy,
  output logic                              locked,
  output logic                              fail,
  output logic [slip_cnt_w(MAX_SLIP)-1:0]   slip_cnt
);

  localparam int SLIP_W = slip_cnt_w(MAX_SLIP);
  localparam int SET_W  = cnt_w(SETTLE_CYC);
  localparam int STEP_W = cnt_w(CHECK_LEN);

  cal_state_e        r_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [SLIP_W-1:0] r_slip_cnt;
  logic              r_first;
  logic              r_bitslip;
  logic              r_busy;
  logic              r_locked;
  logic              r_fail;
  logic              w_step_ok;
  logic [STEP_W-1:0] w_step_cnt;
  logic              w_timeout;

  adc5g_ramp_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (STEP_W)
  ) u_ramp_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .clr      (r_state != ST_CHECK),
    .inc_en   ((r_state == ST_CHECK) && !r_first),
    .step_ok  (w_step_ok),
    .step_cnt (w_step_cnt)
  );

`ifdef GC_CAL_TIMEOUT_EN
  localparam int RUN_W = cnt_w(TIMEOUT_CYC);
  logic [RUN_W-1:0] r_run_cnt;

  // Counts busy cycles; the TIMEOUT_CYC-th busy cycle is the last one.
  assign w_timeout = (r_run_cnt == RUN_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt <= '0;
    end else if (!r_busy) begin
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_slip_cnt   <= '0;
      r_first      <= 1'b0;
      r_bitslip    <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_slip_cnt   <= '0;
            r_busy       <= 1'b1;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            r_state      <= ST_CHECK;
            r_settle_cnt <= '0;
            r_first      <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        ST_CHECK: begin
          r_first <= 1'b0;
          // First CHECK cycle only loads the reference sample into the checker.
          if (!r_first) begin
            if (!w_step_ok) begin
              if (r_slip_cnt < SLIP_W'(MAX_SLIP)) begin
                r_state    <= ST_SLIP;
                r_bitslip  <= 1'b1;
                r_slip_cnt <= r_slip_cnt + SLIP_W'(1);
              end else begin
                r_state <= ST_FAIL;
                r_busy  <= 1'b0;
                r_fail  <= 1'b1;
              end
            end else if (w_step_cnt == STEP_W'(CHECK_LEN - 2)) begin
              r_state  <= ST_LOCKED;
              r_busy   <= 1'b0;
              r_locked <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          r_state <= ST_SETTLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Timeout outranks any lock or slip decided in the same cycle.
      if (r_busy && w_timeout) begin
        r_state    <= ST_FAIL;
        r_busy     <= 1'b0;
        r_fail     <= 1'b1;
        r_locked   <= 1'b0;
        r_bitslip  <= 1'b0;
        r_slip_cnt <= r_slip_cnt;
      end
    end
  end

  assign bitslip  = r_bitslip;
  assign busy     = r_busy;
  assign locked   = r_locked;
  assign fail     = r_fail;
  assign slip_cnt = r_slip_cnt;
  assign gray_en  = r_busy ? 1'b0 : cfg_gray_en;

endmodule

// File: tb/tb_adc5g_gc_cal_ctrl.sv
// Scoreboard bench for adc5g_gc_cal_ctrl: scenarios push expected bitslip/end events,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_adc5g_gc_cal_ctrl;

  typedef enum {M_RAMP, M_CONST, M_MISALIGN} mode_e;

  typedef struct {
    bit is_end;
    int rel;
    int slip;
    bit locked;
    bit fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cfg_gray_en = 1'b1;
  logic [7:0] din = 8'h00;
  logic       gray_en, bitslip, busy, locked, fail;
  logic [2:0] slip_cnt;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    mon_rel;
  int    slips_seen = 0;
  mode_e mode = M_RAMP;
  logic [7:0] ramp = 8'h00;
  logic  prev_locked = 1'b0;
  logic  prev_fail = 1'b0;

  adc5g_gc_cal_ctrl #(
    .DATA_WIDTH (8),
    .SETTLE_CYC (4),
    .CHECK_LEN  (16),
    .MAX_SLIP   (7)
`ifdef GC_CAL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(30)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_gray_en (cfg_gray_en),
    .din         (din),
    .gray_en     (gray_en),
    .bitslip     (bitslip),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .slip_cnt    (slip_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Deserializer model: ramp source that only aligns after three bitslips in M_MISALIGN.
  always @(posedge clk) begin
    #2;
    if (bitslip) slips_seen++;
    case (mode)
      M_RAMP:  din = ramp;
      M_CONST: din = 8'h5A;
      default: din = (slips_seen >= 3) ? ramp : 8'h5A;
    endcase
    ramp = ramp + 8'd1;
  end

  // Monitor: pops the scoreboard on every bitslip pulse and every lock/fail rise.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      mon_rel = cyc - start_cyc;
      if (locked && fail) check("locked_and_fail", 1, 0);
      if (busy) check("gray_en_while_busy", gray_en, 0);
      if (bitslip || (locked && !prev_locked) || (fail && !prev_fail)) begin
        check("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("event_kind_is_end", !bitslip, e.is_end);
          check("event_cycle", mon_rel, e.rel);
          check("event_slip_cnt", slip_cnt, e.slip);
          if (e.is_end) begin
            check("end_locked", locked, e.locked);
            check("end_fail", fail, e.fail);
            check("end_busy", busy, 0);
            check("end_gray_en", gray_en, cfg_gray_en);
          end
        end
      end
    end
    prev_locked = locked;
    prev_fail   = fail;
  end

  task automatic push_slip(input int rel, input int slip);
    exp_q.push_back('{is_end: 1'b0, rel: rel, slip: slip, locked: 1'b0, fail: 1'b0});
  endtask

  task automatic push_end(input int rel, input int slip, input bit lk, input bit fl);
    exp_q.push_back('{is_end: 1'b1, rel: rel, slip: slip, locked: lk, fail: fl});
  endtask

  // Issue start in cycle N; returns at the negedge of cycle N+1.
  task automatic run(input mode_e m, input logic [7:0] ramp0);
    @(negedge clk);
    mode       = m;
    ramp       = ramp0;
    slips_seen = 0;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", busy, 1);
    check("run_locked_cleared", locked, 0);
    check("run_fail_cleared", fail, 0);
    check("run_slip_cleared", slip_cnt, 0);
    check("run_gray_forced_off", gray_en, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_rel(input int rel);
    for (int i = 0; i < 200; i++) begin
      if (cyc - start_cyc >= rel) break;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bitslip", bitslip, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_slip_cnt", slip_cnt, 0);
    check("rst_gray_en_follows_cfg", gray_en, 1);
    cfg_gray_en = 1'b0;
    #1 check("idle_gray_en_follows_cfg", gray_en, 0);
    cfg_gray_en = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean ramp: lock 21 cycles after start, no slips
    push_end(21, 0, 1'b1, 1'b0);
    run(M_RAMP, 8'h10);
    wait_done(60);

    // Misaligned: three slips, then lock (restart from LOCKED)
    push_slip(7, 1);
    push_slip(14, 2);
    push_slip(21, 3);
    push_end(42, 3, 1'b1, 1'b0);
    run(M_MISALIGN, 8'h00);
    wait_done(100);

`ifndef GC_CAL_TIMEOUT_EN
    // Constant pattern: seven slips then fail, no eighth pulse
    for (int k = 1; k <= 7; k++) push_slip(7 * k, k);
    push_end(56, 7, 1'b0, 1'b1);
    run(M_CONST, 8'h00);
    wait_done(120);
    repeat (20) @(negedge clk);
    check("fail_holds", fail, 1);
    check("fail_slip_cnt_holds", slip_cnt, 7);
`else
    // Timeout: 30 busy cycles then fail with only four slips issued
    for (int k = 1; k <= 4; k++) push_slip(7 * k, k);
    push_end(31, 4, 1'b0, 1'b1);
    run(M_CONST, 8'h00);
    wait_done(120);
    repeat (20) @(negedge clk);
    check("timeout_fail_holds", fail, 1);
    check("timeout_slip_cnt_below_max", slip_cnt < 3'd7, 1);
`endif

    // Wrap-around ramp, restart from FAIL, gray decode returned as disabled
    cfg_gray_en = 1'b0;
    push_end(21, 0, 1'b1, 1'b0);
    run(M_RAMP, 8'hF8);
    wait_done(60);
    cfg_gray_en = 1'b1;
    #1 check("post_lock_gray_en", gray_en, 1);

    // Start while busy is ignored; reset in SETTLE after two slips aborts
    push_slip(7, 1);
    push_slip(14, 2);
    run(M_CONST, 8'h00);
    wait_rel(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(16);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_slip_cnt", slip_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_bitslip", bitslip, 0);
    check("abort_slip_cnt", slip_cnt, 0);
    check("abort_locked", locked, 0);
    check("abort_fail", fail, 0);
    check("abort_scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || bitslip || locked || fail || slip_cnt != 3'd0) begin
        check("idle_after_reset", {busy, bitslip, locked, fail, slip_cnt}, 0);
        break;
      end
    end
    check("idle_after_reset_busy", busy, 0);
    check("idle_after_reset_slip_cnt", slip_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, expected < 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
